// File: rtl/led_bank_pkg.sv
// Shared types and constants for the LED blinker bank.
package led_bank_pkg;

  // Per-channel output mode.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  // Number of flops in the reset-release synchroniser.
  localparam int SYNC_DEPTH = 2;

  // LED level for a given mode, blink state and PWM comparison result.
  function automatic logic mode_led(input mode_e mode, input logic blink_state,
                                    input logic pwm_high);
    logic v;
    case (mode)
      MODE_OFF:   v = 1'b0;
      MODE_ON:    v = 1'b1;
      MODE_BLINK: v = blink_state;
      MODE_PWM:   v = pwm_high;
      default:    v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED/heartbeat channel: config registers, period counter, blink state,
// registered wrap strobe and registered LED output.
module led_channel
  import led_bank_pkg::*;
#(
  parameter int CNT_W      = 26,
  parameter int PWM_W      = 8,
  parameter int DEF_PERIOD = 50000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_srst,
  input  logic             i_cfg_we,
  input  logic [CNT_W-1:0] i_cfg_period,
  input  mode_e            i_cfg_mode,
  input  logic [PWM_W-1:0] i_cfg_duty,
  input  logic             i_sync,
  input  logic [PWM_W-1:0] i_pwm_cnt,
  output logic             o_led,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] DEF_P    = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PWM_W-1:0] DUTY_ZERO = {PWM_W{1'b0}};

  logic [CNT_W-1:0] r_period;
  mode_e            r_mode;
  logic [PWM_W-1:0] r_duty;
  logic [CNT_W-1:0] r_cnt;
  logic             r_state;
  logic             r_wrap;
  logic             r_led;

  logic [CNT_W-1:0] w_period_nx;
  mode_e            w_mode_nx;
  logic [PWM_W-1:0] w_duty_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_state_nx;
  logic             w_wrap_nx;
  logic             w_led_nx;

  // Next-state: soft reset, then config/sync phase restart, then normal counting.
  always_comb begin
    w_period_nx = r_period;
    w_mode_nx   = r_mode;
    w_duty_nx   = r_duty;
    w_cnt_nx    = r_cnt;
    w_state_nx  = r_state;
    w_wrap_nx   = 1'b0;
    w_led_nx    = 1'b0;

    if (i_srst) begin
      w_period_nx = DEF_P;
      w_mode_nx   = MODE_BLINK;
      w_duty_nx   = DUTY_ZERO;
      w_cnt_nx    = CNT_ZERO;
      w_state_nx  = 1'b0;
    end else if (i_cfg_we || i_sync) begin
      // A write or a sync restarts the phase and swallows any wrap due now.
      if (i_cfg_we) begin
        w_period_nx = i_cfg_period;
        w_mode_nx   = i_cfg_mode;
        w_duty_nx   = i_cfg_duty;
      end else begin
        w_period_nx = r_period;
        w_mode_nx   = r_mode;
        w_duty_nx   = r_duty;
      end
      w_cnt_nx   = CNT_ZERO;
      w_state_nx = 1'b0;
    end else if (r_period == CNT_ZERO) begin
      // Zero period freezes the channel.
      w_cnt_nx = CNT_ZERO;
    end else if (r_cnt == (r_period - CNT_ONE)) begin
      w_cnt_nx   = CNT_ZERO;
      w_state_nx = ~r_state;
      w_wrap_nx  = 1'b1;
    end else begin
      w_cnt_nx = r_cnt + CNT_ONE;
    end

    // LED follows the post-edge mode/state so a blink toggle shows with its wrap.
    if (i_srst) begin
      w_led_nx = 1'b0;
    end else begin
      w_led_nx = mode_led(w_mode_nx, w_state_nx, (i_pwm_cnt < w_duty_nx));
    end
  end

  // Channel state registers with asynchronous clear to reset configuration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period <= DEF_P;
      r_mode   <= MODE_BLINK;
      r_duty   <= DUTY_ZERO;
      r_cnt    <= CNT_ZERO;
      r_state  <= 1'b0;
      r_wrap   <= 1'b0;
      r_led    <= 1'b0;
    end else begin
      r_period <= w_period_nx;
      r_mode   <= w_mode_nx;
      r_duty   <= w_duty_nx;
      r_cnt    <= w_cnt_nx;
      r_state  <= w_state_nx;
      r_wrap   <= w_wrap_nx;
      r_led    <= w_led_nx;
    end
  end

  assign o_led  = r_led;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/led_blinker_bank.sv
// Bank of NCH LED/heartbeat channels sharing one PWM counter, with its own
// reset-release synchroniser exported for neighbouring logic.
module led_blinker_bank
  import led_bank_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int CNT_W      = 26,
  parameter int PWM_W      = 8,
  parameter int DEF_PERIOD = 50000000
) (
  input  logic                                     sys_clk,
  input  logic                                     sys_rst_n,
  input  logic                                     cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_addr,
  input  logic [CNT_W-1:0]                         cfg_period,
  input  logic [1:0]                               cfg_mode,
  input  logic [PWM_W-1:0]                         cfg_duty,
  input  logic                                     sync_req,
  output logic [NCH-1:0]                           led,
  output logic [NCH-1:0]                           wrap,
  output logic                                     rst_sync
);

  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [SYNC_DEPTH-1:0] r_rst_pipe;
  logic [PWM_W-1:0]      r_pwm_cnt;
  logic                  w_srst;
  logic [NCH-1:0]        w_ch_we;
  mode_e                 w_cfg_mode;

  // Reset synchroniser: asserts immediately, releases after SYNC_DEPTH edges.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rst_pipe <= {SYNC_DEPTH{1'b1}};
    end else begin
      r_rst_pipe <= {r_rst_pipe[SYNC_DEPTH-2:0], 1'b0};
    end
  end

  assign w_srst   = r_rst_pipe[SYNC_DEPTH-1];
  assign rst_sync = r_rst_pipe[SYNC_DEPTH-1];

  // Shared free-running PWM counter; restarted by sync so duty phase is aligned.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pwm_cnt <= {PWM_W{1'b0}};
    end else if (w_srst || sync_req) begin
      r_pwm_cnt <= {PWM_W{1'b0}};
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  assign w_cfg_mode = mode_e'(cfg_mode);

  // Addresses with no matching channel decode to nothing.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_ch_we[gi] = cfg_we && (cfg_addr == AW'(gi));

    led_channel #(
      .CNT_W      (CNT_W),
      .PWM_W      (PWM_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ch (
      .i_clk        (sys_clk),
      .i_rst_n      (sys_rst_n),
      .i_srst       (w_srst),
      .i_cfg_we     (w_ch_we[gi]),
      .i_cfg_period (cfg_period),
      .i_cfg_mode   (w_cfg_mode),
      .i_cfg_duty   (cfg_duty),
      .i_sync       (sync_req),
      .i_pwm_cnt    (r_pwm_cnt),
      .o_led        (led[gi]),
      .o_wrap       (wrap[gi])
    );
  end

endmodule
